// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared definitions for the 9-bit CPU fetch/hazard control.
//                Provides the fetch state encoding, the architectural register
//                indices with special roles, the NOP encoding used when IF/ID
//                is flushed or a bubble enters ID/EX, and a saturating
//                increment helper for the performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

  // Registers with dedicated roles in the ISA. Hazard detection treats them
  // exactly like any other index; they are listed here for the decoder side.
  localparam logic [3:0] ADR_REG  = 4'd4;
  localparam logic [3:0] MATH_REG = 4'd5;
  localparam logic [3:0] CNT_REG  = 4'd7;

  // Instruction word that the pipeline registers load on flush / bubble.
  localparam logic [8:0] NOP_INSTR = 9'h000;

  // Performance counter width.
  localparam int PERF_W = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (v == {PERF_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_hazard_ctrl_if.sv
// ============================================================================
//  Module      : fetch_hazard_ctrl_if
//  Description : Bundle of every signal between the fetch/hazard controller
//                and its neighbours (instruction memory, decode control,
//                EX branch comparator). Names carry the controller's view:
//                _i = into the controller, _o = out of it.
//  Modports    : master - the environment driving the controller
//                slave  - the controller itself
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_hazard_ctrl_if #(
  parameter int PC_W = 8
) ();
  import pipe_ctrl_pkg::*;

  // Control inputs
  logic              start_req_i;
  logic              id_halt_i;
  logic [3:0]        id_read0_i;
  logic [3:0]        id_read1_i;
  logic              id_uses_r1_i;
  logic              ex_mem_read_i;
  logic [3:0]        ex_write_reg_i;
  logic              ex_branch_taken_i;
  logic [PC_W-1:0]   ex_branch_target_i;

  // Fetch / pipeline control outputs
  logic [PC_W-1:0]   pc_o;
  logic              if_valid_o;
  logic              if_id_write_o;
  logic              if_id_flush_o;
  logic              id_ex_bubble_o;
  logic              running_o;
  logic              done_o;
  logic [PERF_W-1:0] cycle_cnt_o;
  logic [PERF_W-1:0] stall_cnt_o;
  logic [PERF_W-1:0] flush_cnt_o;

  modport master (
    output start_req_i, id_halt_i, id_read0_i, id_read1_i, id_uses_r1_i,
           ex_mem_read_i, ex_write_reg_i, ex_branch_taken_i, ex_branch_target_i,
    input  pc_o, if_valid_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o,
           running_o, done_o, cycle_cnt_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  start_req_i, id_halt_i, id_read0_i, id_read1_i, id_uses_r1_i,
           ex_mem_read_i, ex_write_reg_i, ex_branch_taken_i, ex_branch_target_i,
    output pc_o, if_valid_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o,
           running_o, done_o, cycle_cnt_o, stall_cnt_o, flush_cnt_o
  );

endinterface

`default_nettype wire

// File: rtl/load_use_detect.sv
// ============================================================================
//  Module      : load_use_detect
//  Description : Combinational load-use hazard detector. Flags a stall when
//                the instruction in EX is a load whose destination is read by
//                the instruction in ID. read1 only counts when ID really uses
//                it. No register index is exempt.
//  Ports       : id_read0_i, id_read1_i  - ID source register indices
//                id_uses_r1_i            - ID instruction reads read1
//                ex_mem_read_i           - EX instruction is a load
//                ex_write_reg_i          - EX destination register
//                stall_o                 - load-use hazard present
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_use_detect (
  input  wire logic [3:0] id_read0_i,
  input  wire logic [3:0] id_read1_i,
  input  wire logic       id_uses_r1_i,
  input  wire logic       ex_mem_read_i,
  input  wire logic [3:0] ex_write_reg_i,
  output logic            stall_o
);

  logic hit_r0_w;
  logic hit_r1_w;

  assign hit_r0_w = (ex_write_reg_i == id_read0_i);
  assign hit_r1_w = id_uses_r1_i && (ex_write_reg_i == id_read1_i);
  assign stall_o  = ex_mem_read_i && (hit_r0_w || hit_r1_w);

endmodule

`default_nettype wire

// File: rtl/fetch_hazard_ctrl.sv
// ============================================================================
//  Module      : fetch_hazard_ctrl
//  Description : Instruction fetch sequencer and hazard controller for the
//                9-bit pipelined CPU. Owns the PC and the IDLE/RUN/DRAIN/
//                HALTED state machine; resolves branch flushes, load-use
//                stalls and the orderly drain after a decode-stage halt.
//  Ports       : clk    - system clock, rising edge
//                reset  - asynchronous active-high reset
//                bus    - fetch_hazard_ctrl_if.slave (all control I/O)
//  Options     : FETCH_PERF_CNT_EN - when defined, cycle/stall/flush counters
//                are implemented; otherwise the counter outputs read zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int              PC_W         = 8,
  parameter logic [PC_W-1:0] RESET_PC     = '0,
  parameter int              DRAIN_CYCLES = 3
) (
  input  wire logic          clk,
  input  wire logic          reset,
  fetch_hazard_ctrl_if.slave bus
);

  localparam int               DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES - 1);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q,    pc_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;

  logic lu_stall_w;
  logic if_valid_w;
  logic if_id_write_w;
  logic if_id_flush_w;
  logic id_ex_bubble_w;

  // --------------------------------------------------------------------------
  // Load-use hazard detection
  // --------------------------------------------------------------------------
  load_use_detect u_load_use_detect (
    .id_read0_i     (bus.id_read0_i),
    .id_read1_i     (bus.id_read1_i),
    .id_uses_r1_i   (bus.id_uses_r1_i),
    .ex_mem_read_i  (bus.ex_mem_read_i),
    .ex_write_reg_i (bus.ex_write_reg_i),
    .stall_o        (lu_stall_w)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drain_q <= drain_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and pipeline control
  // --------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    drain_d        = drain_q;
    if_valid_w     = 1'b0;
    if_id_write_w  = 1'b0;
    if_id_flush_w  = 1'b0;
    id_ex_bubble_w = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (bus.start_req_i) begin
          state_d = ST_RUN;
          pc_d    = RESET_PC;
        end
      end

      ST_RUN: begin
        if_valid_w = 1'b1;
        if (bus.ex_branch_taken_i) begin
          // Redirect wins over everything: the ID instruction (including a
          // halt) is on the wrong path and gets squashed.
          pc_d           = bus.ex_branch_target_i;
          if_id_flush_w  = 1'b1;
          id_ex_bubble_w = 1'b1;
        end else if (lu_stall_w) begin
          // Freeze IF and IF/ID, let the load advance with a NOP behind it.
          id_ex_bubble_w = 1'b1;
        end else if (bus.id_halt_i) begin
          // Halt proceeds down the pipe; the fetched slot behind it is dropped.
          if_id_flush_w = 1'b1;
          state_d       = ST_DRAIN;
          drain_d       = DRAIN_INIT;
        end else begin
          pc_d          = pc_q + 1'b1;
          if_id_write_w = 1'b1;
        end
      end

      ST_DRAIN: begin
        // Halt travels through EX, MEM, WB; nothing new is fetched.
        if (drain_q == '0) begin
          state_d = ST_HALTED;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.pc_o           = pc_q;
  assign bus.if_valid_o     = if_valid_w;
  assign bus.if_id_write_o  = if_id_write_w;
  assign bus.if_id_flush_o  = if_id_flush_w;
  assign bus.id_ex_bubble_o = id_ex_bubble_w;
  assign bus.running_o      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign bus.done_o         = (state_q == ST_HALTED);

  // --------------------------------------------------------------------------
  // Performance counters
  // --------------------------------------------------------------------------
`ifdef FETCH_PERF_CNT_EN
  logic [PERF_W-1:0] cycle_cnt_q;
  logic [PERF_W-1:0] stall_cnt_q;
  logic [PERF_W-1:0] flush_cnt_q;
  logic              launch_w;
  logic              active_w;
  logic              stall_evt_w;
  logic              flush_evt_w;

  assign launch_w    = ((state_q == ST_IDLE) || (state_q == ST_HALTED)) && bus.start_req_i;
  assign active_w    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign flush_evt_w = (state_q == ST_RUN) && bus.ex_branch_taken_i;
  // Only a stall that actually takes effect counts; a branch outranks it.
  assign stall_evt_w = (state_q == ST_RUN) && !bus.ex_branch_taken_i && lu_stall_w;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (launch_w) begin
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (active_w)    cycle_cnt_q <= sat_inc(cycle_cnt_q);
      if (stall_evt_w) stall_cnt_q <= sat_inc(stall_cnt_q);
      if (flush_evt_w) flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  assign bus.cycle_cnt_o = cycle_cnt_q;
  assign bus.stall_cnt_o = stall_cnt_q;
  assign bus.flush_cnt_o = flush_cnt_q;
`else
  assign bus.cycle_cnt_o = '0;
  assign bus.stall_cnt_o = '0;
  assign bus.flush_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_hazard_ctrl.sv
// ============================================================================
//  Module      : tb_fetch_hazard_ctrl
//  Description : Self-checking bench for fetch_hazard_ctrl. Directed stimulus
//                pushes hand-computed expectations into a scoreboard queue;
//                a monitor pops and compares them mid-cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_hazard_ctrl;
  import pipe_ctrl_pkg::*;

`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Flag order: {if_valid, if_id_write, if_id_flush, id_ex_bubble, running, done}
  localparam logic [5:0] F_IDLE  = 6'b000000;
  localparam logic [5:0] F_RUN   = 6'b110010;
  localparam logic [5:0] F_STALL = 6'b100110;
  localparam logic [5:0] F_BR    = 6'b101110;
  localparam logic [5:0] F_HALT  = 6'b101010;
  localparam logic [5:0] F_DRAIN = 6'b000010;
  localparam logic [5:0] F_DONE  = 6'b000001;

  typedef struct {
    int          cyc;
    string       nm;
    logic [7:0]  pc;
    logic [5:0]  fl;
    bit          cc;
    logic [15:0] c;
    logic [15:0] s;
    logic [15:0] f;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc_n = 0;
  int   total = 0;
  int   bad   = 0;
  exp_t sbq[$];
  exp_t e;

  fetch_hazard_ctrl_if #(.PC_W(8)) bus ();

  fetch_hazard_ctrl #(
    .PC_W         (8),
    .RESET_PC     (8'h00),
    .DRAIN_CYCLES (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.start_req_i        = 1'b0;
    bus.id_halt_i          = 1'b0;
    bus.id_read0_i         = 4'd0;
    bus.id_read1_i         = 4'd0;
    bus.id_uses_r1_i       = 1'b0;
    bus.ex_mem_read_i      = 1'b0;
    bus.ex_write_reg_i     = 4'd15;
    bus.ex_branch_taken_i  = 1'b0;
    bus.ex_branch_target_i = 8'h00;
  endtask

  task automatic expect_now(input string nm, input logic [7:0] p, input logic [5:0] fl,
                            input bit cc, input int c, input int s, input int f);
    exp_t x;
    x.cyc = cyc_n;
    x.nm  = nm;
    x.pc  = p;
    x.fl  = fl;
    x.cc  = cc;
    x.c   = PERF ? 16'(c) : 16'h0;
    x.s   = PERF ? 16'(s) : 16'h0;
    x.f   = PERF ? 16'(f) : 16'h0;
    sbq.push_back(x);
  endtask

  // Monitor: compares whatever expectations belong to the current cycle.
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc_n) begin
      logic [5:0] act_fl;
      e = sbq.pop_front();
      act_fl = {bus.if_valid_o, bus.if_id_write_o, bus.if_id_flush_o,
                bus.id_ex_bubble_o, bus.running_o, bus.done_o};
      total++;
      if (e.cyc != cyc_n) begin
        bad++;
        $display("FAIL %s: checked in cycle %0d, required cycle %0d", e.nm, cyc_n, e.cyc);
      end
      total++;
      if (bus.pc_o !== e.pc) begin
        bad++;
        $display("FAIL %s pc: got %h want %h", e.nm, bus.pc_o, e.pc);
      end
      total++;
      if (act_fl !== e.fl) begin
        bad++;
        $display("FAIL %s flags(v,w,fl,bub,run,done): got %b want %b", e.nm, act_fl, e.fl);
      end
      if (e.cc) begin
        total++;
        if (bus.cycle_cnt_o !== e.c || bus.stall_cnt_o !== e.s || bus.flush_cnt_o !== e.f) begin
          bad++;
          $display("FAIL %s counters(cyc,stall,flush): got %0d,%0d,%0d want %0d,%0d,%0d",
                   e.nm, bus.cycle_cnt_o, bus.stall_cnt_o, bus.flush_cnt_o, e.c, e.s, e.f);
        end
      end
    end
  end

  initial begin
    clr_in();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    expect_now("reset_state", 8'h00, F_IDLE, 1, 0, 0, 0);

    step(); bus.start_req_i = 1'b1; expect_now("idle_start", 8'h00, F_IDLE, 0, 0, 0, 0);
    step(); bus.start_req_i = 1'b0; expect_now("run_pc0", 8'h00, F_RUN, 0, 0, 0, 0);
    step(); expect_now("run_pc1", 8'h01, F_RUN, 0, 0, 0, 0);
    step(); bus.start_req_i = 1'b1; expect_now("run_pc2_start_ignored", 8'h02, F_RUN, 0, 0, 0, 0);
    step(); bus.start_req_i = 1'b0; expect_now("run_pc3", 8'h03, F_RUN, 0, 0, 0, 0);

    // ld r2 in EX, ID reads r2 as read0
    step();
    bus.ex_mem_read_i = 1'b1; bus.ex_write_reg_i = 4'd2; bus.id_read0_i = 4'd2;
    expect_now("ld_use_r0", 8'h04, F_STALL, 0, 0, 0, 0);
    step(); bus.ex_mem_read_i = 1'b0; expect_now("after_stall", 8'h04, F_RUN, 0, 0, 0, 0);

    // read1 matches but is not used -> no stall
    step();
    bus.ex_mem_read_i = 1'b1; bus.ex_write_reg_i = CNT_REG; bus.id_read0_i = 4'd3;
    bus.id_read1_i = CNT_REG; bus.id_uses_r1_i = 1'b0;
    expect_now("r1_unused_no_stall", 8'h05, F_RUN, 1, 6, 1, 0);
    step(); bus.id_uses_r1_i = 1'b1; expect_now("ld_use_r1", 8'h06, F_STALL, 0, 0, 0, 0);
    step(); clr_in(); expect_now("after_stall2", 8'h06, F_RUN, 0, 0, 0, 0);

    // Branch with halt and a load-use match in the same cycle: branch wins
    step();
    bus.ex_branch_taken_i = 1'b1; bus.ex_branch_target_i = 8'h40; bus.id_halt_i = 1'b1;
    bus.ex_mem_read_i = 1'b1; bus.ex_write_reg_i = 4'd3; bus.id_read0_i = 4'd3;
    expect_now("branch_with_halt", 8'h07, F_BR, 0, 0, 0, 0);
    step(); clr_in(); expect_now("branch_target", 8'h40, F_RUN, 0, 0, 0, 0);
    step();
    bus.ex_branch_taken_i = 1'b1; bus.ex_branch_target_i = 8'h10;
    expect_now("branch_to_10", 8'h41, F_BR, 0, 0, 0, 0);

    // Halt at 0x10, then drain
    step(); clr_in(); bus.id_halt_i = 1'b1;
    expect_now("halt", 8'h10, F_HALT, 1, 12, 2, 2);
    step();
    bus.ex_branch_taken_i = 1'b1; bus.ex_branch_target_i = 8'h55; bus.start_req_i = 1'b1;
    expect_now("drain1_ignores", 8'h10, F_DRAIN, 0, 0, 0, 0);
    step(); clr_in(); expect_now("drain2", 8'h10, F_DRAIN, 0, 0, 0, 0);
    step(); expect_now("drain3", 8'h10, F_DRAIN, 0, 0, 0, 0);
    step(); expect_now("done_rise", 8'h10, F_DONE, 1, 16, 2, 2);
    step(); bus.start_req_i = 1'b1; expect_now("done_hold", 8'h10, F_DONE, 0, 0, 0, 0);
    step(); bus.start_req_i = 1'b0; expect_now("restart", 8'h00, F_RUN, 1, 0, 0, 0);

    // Wrap from 0xFE
    step();
    bus.ex_branch_taken_i = 1'b1; bus.ex_branch_target_i = 8'hFE;
    expect_now("branch_to_fe", 8'h01, F_BR, 1, 1, 0, 0);
    step(); clr_in(); expect_now("pc_fe", 8'hFE, F_RUN, 0, 0, 0, 0);
    step(); expect_now("pc_ff", 8'hFF, F_RUN, 0, 0, 0, 0);
    step(); expect_now("pc_wrap", 8'h00, F_RUN, 0, 0, 0, 0);

    // Async reset mid-drain
    step(); bus.id_halt_i = 1'b1; expect_now("halt2", 8'h01, F_HALT, 0, 0, 0, 0);
    step(); clr_in(); expect_now("drain_a", 8'h01, F_DRAIN, 0, 0, 0, 0);
    step(); #1 reset = 1'b1;
    expect_now("async_reset", 8'h00, F_IDLE, 1, 0, 0, 0);
    step(); expect_now("reset_held", 8'h00, F_IDLE, 0, 0, 0, 0);
    reset = 1'b0;
    step(); expect_now("idle_after_reset", 8'h00, F_IDLE, 1, 0, 0, 0);

    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (sbq.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_scoreboard: %0d expectations left, required 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, scoreboard depth %0d", sbq.size());
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/fetch_hazard_ctrl.md
Name: fetch_hazard_ctrl

Overview:
- Sequences instruction fetch for the 9-bit pipelined CPU: owns the program counter and the run/halt state machine.
- Resolves hazards between the IF/ID and ID/EX pipeline registers:
  - load-use stalls against an `ld` in EX;
  - flushes on a branch/jump taken in EX;
  - orderly drain after the decoder asserts `start` (halt).
- Sits between instruction memory, the decode-stage control unit and the EX-stage branch comparator.

Parameters:
- PC_W, 8, program counter width; PC wraps modulo 2^PC_W.
- RESET_PC, 0, first fetch address after start.
- DRAIN_CYCLES, 3, cycles after halt leaves ID before `done` (EX, MEM, WB).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start_req  in  1  one-cycle pulse; launches program at RESET_PC.
- id_halt  in  1  decode-stage halt (control unit `start` output).
- id_read0  in  4  decode-stage readReg0.
- id_read1  in  4  decode-stage readReg1.
- id_uses_r1  in  1  instruction in ID actually reads id_read1.
- ex_mem_read  in  1  instruction in EX is `ld` (MemtoReg=1).
- ex_write_reg  in  4  EX-stage destination register.
- ex_branch_taken  in  1  branch/jump in EX resolved taken.
- ex_branch_target  in  PC_W  taken target.
- pc  out  PC_W  fetch address (registered).
- if_valid  out  1  fetch slot holds a real instruction.
- if_id_write  out  1  IF/ID register load enable.
- if_id_flush  out  1  clear IF/ID to NOP.
- id_ex_bubble  out  1  insert NOP into ID/EX.
- running  out  1  state is RUN or DRAIN.
- done  out  1  program halted and pipeline drained.
- cycle_cnt, stall_cnt, flush_cnt  out  16 each  performance counters (see Optional Feature).

Behaviour:
- States: IDLE, RUN, DRAIN, HALTED. Only state, pc, drain counter and perf counters are registered. if_id_write, if_id_flush and id_ex_bubble are combinational from state and same-cycle inputs.
- Reset (asynchronous, any state, including mid-drain): state=IDLE, pc=RESET_PC, drain counter=0, counters=0. All outputs 0 except pc.
- IDLE:
  - if_valid=0 and all enables 0.
  - start_req=1 -> RUN next edge with pc=RESET_PC.
- RUN: if_valid=1. Exactly one case applies per cycle, in priority order:
  1. ex_branch_taken:
     - pc<=ex_branch_target; if_id_flush=1; id_ex_bubble=1; if_id_write=0.
     - id_halt the same cycle is on the wrong path and is ignored.
  2. Load-use, true when ex_mem_read && (ex_write_reg==id_read0 || (id_uses_r1 && ex_write_reg==id_read1)):
     - pc holds; if_id_write=0; id_ex_bubble=1.
     - The stall lasts one cycle; it recurs only if the inputs still match.
  3. id_halt:
     - pc holds; if_id_flush=1 (drop the instruction behind the halt); if_id_write=0.
     - DRAIN next edge, drain counter<=DRAIN_CYCLES-1.
  4. Otherwise: pc<=pc+1 with wrap (0xFF -> 0x00 at PC_W=8); if_id_write=1.
- DRAIN:
  - if_valid=0; if_id_write=0.
  - ex_branch_taken and id_halt are ignored.
  - Counter decrements each cycle; at 0 -> HALTED next edge.
  - HALT to done latency = DRAIN_CYCLES+1 cycles after the halt cycle.
- HALTED:
  - done=1 and held; running=0; pc frozen.
  - start_req -> RUN with pc=RESET_PC; done clears on that edge.
- start_req in RUN or DRAIN is ignored.
- Register indices 4 ($adr), 5 ($math) and 7 ($cnt) are compared like any other index; there is no r0 exemption.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined:
  - cycle_cnt increments every RUN/DRAIN cycle.
  - stall_cnt increments on load-use cycles.
  - flush_cnt increments on branch-flush cycles.
  - All three clear on the start_req that leaves IDLE/HALTED and saturate at 0xFFFF.
- When undefined: the ports remain and are tied to 0; no counter flops are present.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - fetch state enum;
  - register index constants ADR_REG=4, MATH_REG=5, CNT_REG=7;
  - NOP encoding used by flush and bubble.
- One combinational sub-module, load_use_detect: inputs id_read0, id_read1, id_uses_r1, ex_mem_read, ex_write_reg; output stall.

Test Plan:
- Reset, then start_req pulse -> pc 0,1,2,3 on successive cycles; if_id_write=1; running=1.
- `ld` writing r2 in EX, ID reads r2 as read0 -> one cycle with pc held, if_id_write=0, id_ex_bubble=1; then normal increment; stall_cnt=1 when FETCH_PERF_CNT_EN is defined.
- ex_branch_taken with target 0x40 and id_halt in the same cycle -> pc=0x40 next, if_id_flush=1, id_ex_bubble=1, state stays RUN.
- id_halt at pc=0x10 -> if_id_flush=1, pc stays 0x10, done rises exactly 4 cycles later, then start_req -> pc=0 and done=0.
- Ops from 0xFE with no hazards -> pc 0xFE, 0xFF, 0x00 (wrap).
- reset asserted asynchronously during DRAIN -> immediate IDLE, done=0, pc=RESET_PC with no clock edge required.
